// File: rtl/debug_dump_sequencer.sv
// Streams a debug snapshot (PC, cycle count, register file, data memory) over a
// byte-wide UART transmitter, MSB byte first, one byte per transmitter handshake.
module debug_dump_sequencer #(
    parameter int BITS_SIZE  = 32,
    parameter int MEM_WORDS  = 32,
    parameter int SIZE_TRAMA = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_tx_done,
    input  logic [BITS_SIZE-1:0]  i_pc,
    input  logic [BITS_SIZE-1:0]  i_clk_count,
    input  logic [BITS_SIZE-1:0]  i_data_reg_file,
    input  logic [BITS_SIZE-1:0]  i_data_mem,
    output logic [4:0]            o_select_register_dir,
    output logic [BITS_SIZE-1:0]  o_select_mem_dir,
    output logic [SIZE_TRAMA-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [8:0] FIRST_REG = 9'd2;
    localparam logic [8:0] FIRST_MEM = 9'd34;
    localparam logic [8:0] LAST_WORD = 9'(33 + MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        LATCH  = 3'd2,
        SEND   = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [8:0]              word_cnt_r, word_cnt_nxt_s;
    logic [1:0]              byte_cnt_r, byte_cnt_nxt_s;
    logic [BITS_SIZE-1:0]    pc_snap_r, pc_snap_nxt_s;
    logic [BITS_SIZE-1:0]    clk_snap_r, clk_snap_nxt_s;
    logic [BITS_SIZE-1:0]    shift_r, shift_nxt_s;
    logic [4:0]              sel_reg_r, sel_reg_nxt_s;
    logic [BITS_SIZE-1:0]    sel_mem_r, sel_mem_nxt_s;
    logic [SIZE_TRAMA-1:0]   tx_data_r, tx_data_nxt_s;
    logic                    tx_start_r, tx_start_nxt_s;
    logic                    busy_r, busy_nxt_s;
    logic                    done_r, done_nxt_s;

    function automatic logic [SIZE_TRAMA-1:0] pick_byte(input logic [BITS_SIZE-1:0] word,
                                                        input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = word[4*SIZE_TRAMA-1 -: SIZE_TRAMA];
            2'd1:    pick_byte = word[3*SIZE_TRAMA-1 -: SIZE_TRAMA];
            2'd2:    pick_byte = word[2*SIZE_TRAMA-1 -: SIZE_TRAMA];
            default: pick_byte = word[SIZE_TRAMA-1:0];
        endcase
    endfunction

    // Word indices 2..33 map onto registers 0..31; low five bits wrap correctly.
    function automatic logic [4:0] reg_dir_of(input logic [8:0] w);
        if ((w >= FIRST_REG) && (w < FIRST_MEM)) begin
            reg_dir_of = w[4:0] - 5'd2;
        end else begin
            reg_dir_of = 5'd0;
        end
    endfunction

    function automatic logic [BITS_SIZE-1:0] mem_dir_of(input logic [8:0] w);
        if (w >= FIRST_MEM) begin
            mem_dir_of = BITS_SIZE'(w - FIRST_MEM);
        end else begin
            mem_dir_of = {BITS_SIZE{1'b0}};
        end
    endfunction

    // Next-state, counter, snapshot and registered-output computation.
    always_comb begin
        state_nxt_s    = state_r;
        word_cnt_nxt_s = word_cnt_r;
        byte_cnt_nxt_s = byte_cnt_r;
        pc_snap_nxt_s  = pc_snap_r;
        clk_snap_nxt_s = clk_snap_r;
        shift_nxt_s    = shift_r;

        case (state_r)
            IDLE: begin
                if (i_start) begin
                    pc_snap_nxt_s  = i_pc;
                    clk_snap_nxt_s = i_clk_count;
                    word_cnt_nxt_s = 9'd0;
                    byte_cnt_nxt_s = 2'd0;
                    state_nxt_s    = SELECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SELECT: state_nxt_s = LATCH;
            LATCH: begin
                if (word_cnt_r == 9'd0) begin
                    shift_nxt_s = pc_snap_r;
                end else if (word_cnt_r == 9'd1) begin
                    shift_nxt_s = clk_snap_r;
                end else if (word_cnt_r < FIRST_MEM) begin
                    shift_nxt_s = i_data_reg_file;
                end else begin
                    shift_nxt_s = i_data_mem;
                end
                state_nxt_s = SEND;
            end
            SEND: state_nxt_s = WAIT;
            WAIT: begin
                if (!i_tx_done) begin
                    state_nxt_s = WAIT;
                end else if (byte_cnt_r != 2'd3) begin
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    state_nxt_s    = SEND;
                end else if (word_cnt_r < LAST_WORD) begin
                    word_cnt_nxt_s = word_cnt_r + 9'd1;
                    byte_cnt_nxt_s = 2'd0;
                    state_nxt_s    = SELECT;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase

        // Outputs are registered against the state being entered.
        tx_start_nxt_s = (state_nxt_s == SEND);
        done_nxt_s     = (state_nxt_s == DONE);
        busy_nxt_s     = (state_nxt_s == SELECT) || (state_nxt_s == LATCH) ||
                         (state_nxt_s == SEND)   || (state_nxt_s == WAIT);

        if (state_nxt_s == SELECT) begin
            sel_reg_nxt_s = reg_dir_of(word_cnt_nxt_s);
            sel_mem_nxt_s = mem_dir_of(word_cnt_nxt_s);
        end else if ((state_nxt_s == IDLE) || (state_nxt_s == DONE)) begin
            sel_reg_nxt_s = 5'd0;
            sel_mem_nxt_s = {BITS_SIZE{1'b0}};
        end else begin
            sel_reg_nxt_s = sel_reg_r;
            sel_mem_nxt_s = sel_mem_r;
        end

        if (state_nxt_s == SEND) begin
            tx_data_nxt_s = pick_byte(shift_nxt_s, byte_cnt_nxt_s);
        end else begin
            tx_data_nxt_s = tx_data_r;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= IDLE;
            word_cnt_r <= 9'd0;
            byte_cnt_r <= 2'd0;
            pc_snap_r  <= {BITS_SIZE{1'b0}};
            clk_snap_r <= {BITS_SIZE{1'b0}};
            shift_r    <= {BITS_SIZE{1'b0}};
            sel_reg_r  <= 5'd0;
            sel_mem_r  <= {BITS_SIZE{1'b0}};
            tx_data_r  <= {SIZE_TRAMA{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            word_cnt_r <= word_cnt_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            pc_snap_r  <= pc_snap_nxt_s;
            clk_snap_r <= clk_snap_nxt_s;
            shift_r    <= shift_nxt_s;
            sel_reg_r  <= sel_reg_nxt_s;
            sel_mem_r  <= sel_mem_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign o_select_register_dir = sel_reg_r;
    assign o_select_mem_dir      = sel_mem_r;
    assign o_tx_data             = tx_data_r;
    assign o_tx_start            = tx_start_r;
    assign o_busy                = busy_r;
    assign o_done                = done_r;

endmodule

// File: doc/debug_dump_sequencer.md
DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32: width of every dumped word.
REQ-002 SHALL have parameter MEM_WORDS, default 32: number of data-memory words dumped, range 1..256.
REQ-003 SHALL have parameter SIZE_TRAMA, default 8: UART frame width in bits.
REQ-004 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-005 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1: one-cycle request to begin a dump.
REQ-007 SHALL have port i_tx_done, input, 1: UART transmitter one-cycle completion pulse.
REQ-008 SHALL have port i_pc, input, BITS_SIZE: MIPS program counter.
REQ-009 SHALL have port i_clk_count, input, BITS_SIZE: executed-cycle counter.
REQ-010 SHALL have port i_data_reg_file, input, BITS_SIZE: register-file word at o_select_register_dir.
REQ-011 SHALL have port i_data_mem, input, BITS_SIZE: data-memory word at o_select_mem_dir.
REQ-012 SHALL have port o_select_register_dir, output, 5: register index 0..31.
REQ-013 SHALL have port o_select_mem_dir, output, BITS_SIZE: data-memory word index, not byte address.
REQ-014 SHALL have port o_tx_data, output, SIZE_TRAMA: byte to transmit.
REQ-015 SHALL have port o_tx_start, output, 1: one-cycle UART transmit strobe.
REQ-016 SHALL have port o_busy, output, 1: high from the cycle after an accepted i_start until o_done.
REQ-017 SHALL have port o_done, output, 1: one-cycle pulse marking dump completion.

Function
REQ-018 SHALL use states IDLE, SELECT, LATCH, SEND, WAIT, DONE.
REQ-019 SHALL, in IDLE with i_start=1, capture i_pc and i_clk_count into snapshot registers, clear word and byte counters, and go to SELECT.
REQ-020 SHALL dump in this order: PC, clock count, registers 0..31, memory words 0..MEM_WORDS-1; total 2+32+MEM_WORDS words.
REQ-021 SHALL, in SELECT, drive o_select_register_dir or o_select_mem_dir from the word counter and hold it stable for one settle cycle, then go to LATCH.
REQ-022 SHALL, in LATCH, load the 32-bit shift word from the snapshot, i_data_reg_file or i_data_mem per word counter, then go to SEND.
REQ-023 SHALL send each word MSB byte first: bits [31:24], [23:16], [15:8], [7:0].
REQ-024 SHALL, in SEND, assert o_tx_start for exactly one cycle with o_tx_data valid that cycle, then go to WAIT.
REQ-025 SHALL hold o_tx_data stable from SEND until i_tx_done is received.
REQ-026 SHALL, in WAIT on i_tx_done: if byte counter<3, increment it and go to SEND; else, if more words remain, increment the word counter, clear the byte counter and go to SELECT; else go to DONE.
REQ-027 SHALL, in DONE, pulse o_done for one cycle, drop o_busy, and return to IDLE next cycle.
REQ-028 SHALL ignore i_start outside IDLE, including the DONE cycle.
REQ-029 SHALL ignore i_tx_done outside WAIT, including a pulse coincident with o_tx_start.
REQ-030 SHALL keep o_select_register_dir at 0 while dumping PC, clock count or memory, and o_select_mem_dir at 0 outside memory words.
REQ-031 SHALL use a 9-bit word counter; the last word index is 33+MEM_WORDS with no wrap past it.
REQ-032 SHALL not generate o_tx_start more than once per i_tx_done received.

Reset
REQ-033 SHALL, with i_reset=1 at a clock edge, enter IDLE regardless of current state, including mid-byte or mid-word.
REQ-034 SHALL reset all outputs to 0: o_tx_start, o_tx_data, o_busy, o_done, both select buses.
REQ-035 SHALL clear snapshot, shift word and counters on reset; an i_start coincident with i_reset SHALL be ignored.

Verification
REQ-036 Full dump: i_pc=0x00000040, i_clk_count=0x0000001A, reg k=k, mem k=0x100+k, MEM_WORDS=32, tx_done 10 cycles after each strobe -> 264 strobes; first bytes 00 00 00 40 00 00 00 1A; last byte 0x1F; one o_done.
REQ-037 Snapshot: change i_pc to 0xFFFFFFFF after start -> PC bytes still 00 00 00 40.
REQ-038 Spurious handshake: i_tx_done in IDLE and same cycle as o_tx_start -> no state advance, byte repeated only once as expected.
REQ-039 Busy start: second i_start during WAIT -> ignored, total strobe count unchanged.
REQ-040 Reset mid-dump: i_reset after byte 50 -> next cycle all outputs 0, IDLE; new i_start restarts from PC byte 0x00.
REQ-041 MEM_WORDS=1 -> 140 strobes; o_select_mem_dir never exceeds 0.
